// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - frame opcodes, reply codes and FSM state encoding for uart_bus_master
// State list depends on UART_BUS_CSUM_EN (adds the checksum state).
package uart_bus_master_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
`ifdef UART_BUS_CSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_BUS  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

endpackage

// File: rtl/bus_resp_serializer.sv
// rtl/bus_resp_serializer.sv - sends a 1- or 4-byte reply word MSB first over a valid/ready byte port
// done_o is combinational so the parent can leave its reply state on the accepting edge.
module bus_resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        four_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [31:0] word_q;
    logic [2:0]  left_q;
    logic        valid_q;

    assign tx_data_o  = word_q[31:24];
    assign tx_valid_o = valid_q;
    assign done_o     = valid_q && tx_ready_i && (left_q == 3'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= 32'h0;
            left_q  <= 3'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            left_q  <= four_i ? 3'd4 : 3'd1;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready_i) begin
            // next byte is presented on the cycle right after acceptance
            word_q <= {word_q[23:0], 8'h00};
            left_q <= left_q - 3'd1;
            if (left_q == 3'd1) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART byte-frame parser driving single-cycle peripheral bus reads/writes
// Optional checksum byte per frame when UART_BUS_CSUM_EN is defined.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        overrun
);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        op_wr_q;
    logic [31:0] addr_sr_q, addr_sr_d;
    logic [31:0] data_sr_q, data_sr_d;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] tmo_q;
    logic        rd_q, wr_q, overrun_q;
`ifdef UART_BUS_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        ser_load, ser_four, ser_done;
    logic [31:0] ser_word;
    logic        idle_in, start, tmo_hit;

    assign rd      = rd_q;
    assign wr      = wr_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        addr_sr_d = {addr_sr_q[23:0], rx_data};
        data_sr_d = {data_sr_q[23:0], rx_data};
`ifdef UART_BUS_CSUM_EN
        csum_d    = csum_q ^ rx_data;
`endif
        ser_load  = 1'b0;
        ser_word  = 32'h0;
        ser_four  = 1'b0;
        if (state_q == ST_BUS) begin
            ser_load = 1'b1;
            if (op_wr_q) begin
                ser_word = {RSP_OK, 24'h0};
            end else begin
                ser_word = rdata;
                ser_four = 1'b1;
            end
        end
`ifdef UART_BUS_CSUM_EN
        else if (state_q == ST_CSUM && rx_valid && rx_data != csum_q) begin
            ser_load = 1'b1;
            ser_word = {RSP_ERR, 24'h0};
        end
`endif
        // a byte arriving as the last reply byte goes out is parsed as a fresh frame start
        idle_in = rx_valid && (state_q == ST_IDLE || (state_q == ST_RESP && ser_done));
        start   = idle_in && (rx_data == OP_WR || rx_data == OP_RD);
        tmo_hit = (TIMEOUT != 0) && !rx_valid && (tmo_q == TIMEOUT - 32'd1);
    end

    bus_resp_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load),
        .word_i     (ser_word),
        .four_i     (ser_four),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .done_o     (ser_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            op_wr_q   <= 1'b0;
            addr_sr_q <= 32'h0;
            data_sr_q <= 32'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            tmo_q     <= 32'h0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_BUS_CSUM_EN
            csum_q    <= 8'h0;
`endif
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (start) begin
                op_wr_q <= (rx_data == OP_WR);
                cnt_q   <= 2'd0;
                tmo_q   <= 32'h0;
`ifdef UART_BUS_CSUM_EN
                csum_q  <= rx_data;
`endif
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (rx_valid) begin
                        tmo_q <= 32'h0;
                        cnt_q <= cnt_q + 2'd1;
`ifdef UART_BUS_CSUM_EN
                        csum_q <= csum_d;
`endif
                        if (state_q == ST_ADDR) begin
                            addr_sr_q <= addr_sr_d;
                        end else begin
                            data_sr_q <= data_sr_d;
                        end
                        if (cnt_q == 2'd3) begin
                            if (state_q == ST_ADDR && op_wr_q) begin
                                state_q <= ST_DATA;
                            end else begin
`ifdef UART_BUS_CSUM_EN
                                state_q <= ST_CSUM;
`else
                                state_q <= ST_BUS;
                                if (op_wr_q) begin
                                    addr_q  <= addr_sr_q;
                                    wdata_q <= data_sr_d;
                                    wr_q    <= 1'b1;
                                end else begin
                                    addr_q  <= addr_sr_d;
                                    rd_q    <= 1'b1;
                                end
`endif
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                        tmo_q   <= 32'h0;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`ifdef UART_BUS_CSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        tmo_q <= 32'h0;
                        if (rx_data == csum_q) begin
                            state_q <= ST_BUS;
                            addr_q  <= addr_sr_q;
                            if (op_wr_q) begin
                                wdata_q <= data_sr_q;
                                wr_q    <= 1'b1;
                            end else begin
                                rd_q    <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end else if (tmo_hit) begin
                        state_q <= ST_IDLE;
                        tmo_q   <= 32'h0;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`endif
                ST_BUS: begin
                    state_q <= ST_RESP;
                    if (rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (ser_done) begin
                        state_q <= start ? ST_ADDR : ST_IDLE;
                    end else if (rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed and randomized frame checks for uart_bus_master
// Bus model is a 16-word register file; replies compared against a behavioural memory model.
module tb_uart_bus_master;

    localparam int unsigned TMO = 100;
    localparam logic [7:0] C_WR  = 8'h57;
    localparam logic [7:0] C_RD  = 8'h52;
    localparam logic [7:0] C_OK  = 8'h4B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        rd, wr, busy, overrun;
    logic [31:0] addr, wdata, rdata;

    logic [31:0] mem [16];
    logic [31:0] model [16];

    int ncmp = 0;
    int nfail = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, tv_cnt = 0;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .overrun  (overrun)
    );

    assign rdata = mem[addr[5:2]];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? 32'h0000003C : (32'hC0DE0000 | i);
        end else if (wr) begin
            mem[addr[5:2]] <= wdata;
        end
    end

    always @(posedge clk) begin
        if (wr) wr_cnt++;
        if (rd) rd_cnt++;
        if (rd && wr) both_cnt++;
        if (tx_valid) tv_cnt++;
    end

    task automatic model_init();
        for (int i = 0; i < 16; i++) model[i] = (i == 4) ? 32'h0000003C : (32'hC0DE0000 | i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bytes(input logic [7:0] fr[$]);
        foreach (fr[i]) begin
            rx_data  = fr[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i != fr.size() - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic get_reply(input int n, input int hold, input bit inject, output logic [7:0] rep[$]);
        int got = 0, cyc = 0, held = 0;
        bit pend = 1'b0, injected = 1'b0;
        logic [7:0] prev = 8'h0;
        rep = {};
        while (got < n && cyc < 500) begin
            if (tx_valid) begin
                if (pend) chk("tx_data_stable", 32'(tx_data), 32'(prev));
                if (held < hold) begin
                    tx_ready = 1'b0;
                    held++;
                end else begin
                    tx_ready = ($urandom_range(0, 2) != 0);
                end
                if (inject && !injected) begin
                    rx_data  = 8'h00;
                    rx_valid = 1'b1;
                    tx_ready = 1'b0;
                    injected = 1'b1;
                end
                if (tx_ready) begin
                    rep.push_back(tx_data);
                    got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    prev = tx_data;
                end
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            rx_valid = 1'b0;
            cyc++;
        end
        tx_ready = 1'b0;
        if (got < n) chk("reply_bytes_received", 32'(got), 32'(n));
    endtask

    task automatic build_frame(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                               output logic [7:0] fr[$]);
        logic [7:0] cs;
        fr = {is_wr ? C_WR : C_RD, a[31:24], a[23:16], a[15:8], a[7:0]};
        if (is_wr) fr = {fr, d[31:24], d[23:16], d[15:8], d[7:0]};
        cs = 8'h0;
        foreach (fr[i]) cs ^= fr[i];
`ifdef UART_BUS_CSUM_EN
        fr.push_back(cs);
`endif
    endtask

    task automatic xact(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input bit inject);
        logic [7:0] fr[$];
        logic [7:0] rep[$];
        logic [31:0] exp_word;
        int n;
        build_frame(is_wr, a, d, fr);
        send_bytes(fr);
        chk("wr_strobe", 32'(wr), 32'(is_wr));
        chk("rd_strobe", 32'(rd), 32'(!is_wr));
        chk("bus_addr", addr, a);
        if (is_wr) begin
            chk("bus_wdata", wdata, d);
            model[a[5:2]] = d;
            exp_word = {C_OK, 24'h0};
            n = 1;
        end else begin
            exp_word = model[a[5:2]];
            n = 4;
        end
        @(negedge clk);
        chk("strobe_one_cycle", 32'(rd | wr), 32'd0);
        chk("first_tx_valid", 32'(tx_valid), 32'd1);
        get_reply(n, hold, inject, rep);
        for (int i = 0; i < n && i < rep.size(); i++)
            chk($sformatf("reply_byte%0d", i), 32'(rep[i]), 32'(exp_word[31 - 8*i -: 8]));
        chk("idle_after_reply", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] rep[$];
        int rd0, tv0;
        model_init();
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rd_wr", 32'({rd, wr}), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        xact(1'b1, 32'h4000000C, 32'h000000A5, 0, 1'b0);
        xact(1'b0, 32'h40000010, 32'h0, 20, 1'b0);
        xact(1'b0, 32'h4000000C, 32'h0, 0, 1'b0);

        fr = {8'h13};
        send_bytes(fr);
        chk("junk_stays_idle", 32'(busy), 32'd0);
        rd0 = rd_cnt;
        tv0 = tv_cnt;
        fr = {C_RD, 8'h40};
        send_bytes(fr);
        repeat (50) @(negedge clk);
        chk("busy_before_timeout", 32'(busy), 32'd1);
        repeat (60) @(negedge clk);
        chk("idle_after_timeout", 32'(busy), 32'd0);
        chk("no_rd_on_timeout", 32'(rd_cnt), 32'(rd0));
        chk("no_reply_on_timeout", 32'(tv_cnt), 32'(tv0));
        xact(1'b0, 32'h40000010, 32'h0, 0, 1'b0);
        chk("no_overrun_yet", 32'(overrun), 32'd0);

        for (int k = 0; k < 10; k++) begin
            logic [31:0] a;
            a = 32'h40000000 | 32'($urandom_range(0, 63));
            xact(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b0);
        end

        xact(1'b0, 32'h40000010, 32'h0, 0, 1'b1);
        chk("overrun_set", 32'(overrun), 32'd1);
        xact(1'b1, 32'h40000020, 32'h12345678, 0, 1'b0);
        xact(1'b0, 32'h40000020, 32'h0, 0, 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

`ifdef UART_BUS_CSUM_EN
        xact(1'b0, 32'h40000000, 32'h0, 0, 1'b0);
        rd0 = rd_cnt;
        fr = {C_RD, 8'h40, 8'h00, 8'h00, 8'h00, 8'h13};
        send_bytes(fr);
        get_reply(1, 0, 1'b0, rep);
        if (rep.size() > 0) chk("csum_err_reply", 32'(rep[0]), 32'h45);
        chk("csum_err_no_rd", 32'(rd_cnt), 32'(rd0));
        chk("csum_err_idle", 32'(busy), 32'd0);
`endif

        build_frame(1'b0, 32'h40000010, 32'h0, fr);
        send_bytes(fr);
        @(negedge clk);
        get_reply(2, 0, 1'b0, rep);
        reset = 1'b0;
        #1;
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_rd_wr", 32'({rd, wr}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_init();
        tv0 = tv_cnt;
        tx_ready = 1'b1;
        repeat (30) @(negedge clk);
        tx_ready = 1'b0;
        chk("no_resume_after_reset", 32'(tv_cnt), 32'(tv0));
        xact(1'b0, 32'h40000010, 32'h0, 0, 1'b0);
        chk("no_double_strobe", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
